// File: rtl/maze_generator_pkg.sv
// Shared maze geometry defaults, FSM encoding and LFSR constants.
// Used by maze_generator, maze_lfsr16 and the downstream renderer.
package maze_generator_pkg;

  localparam int          DEF_MAZE_W    = 8;
  localparam int          DEF_MAZE_H    = 6;
  localparam int          DEF_X_BITS    = 3;
  localparam int          DEF_Y_BITS    = 3;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CARVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // An all-zero Galois LFSR would lock up, so zero is replaced by one.
  function automatic logic [15:0] nonzero_seed(input logic [15:0] seed);
    return (seed == 16'h0000) ? 16'h0001 : seed;
  endfunction

endpackage

// File: rtl/maze_lfsr16.sv
// Free-running 16-bit right-shifting Galois LFSR with optional parallel load.
// Both the reset seed and a loaded value are guarded against zero.
module maze_lfsr16
  import maze_generator_pkg::*;
#(
  parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= nonzero_seed(SEED);
    end else if (load) begin
      q <= nonzero_seed(load_val);
    end else begin
      q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/maze_generator.sv
// Binary-tree perfect-maze generator with wall storage and a registered read port.
// Optional macro MAZE_SEED_IN_EN adds seed_in, loaded into the LFSR on an accepted start.
module maze_generator
  import maze_generator_pkg::*;
#(
  parameter int          MAZE_W    = DEF_MAZE_W,
  parameter int          MAZE_H    = DEF_MAZE_H,
  parameter int          X_BITS    = DEF_X_BITS,
  parameter int          Y_BITS    = DEF_Y_BITS,
  parameter logic [15:0] LFSR_SEED = DEF_LFSR_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [X_BITS-1:0] rd_x,
  input  logic [Y_BITS-1:0] rd_y,
`ifdef MAZE_SEED_IN_EN
  input  logic [15:0]       seed_in,
`endif
  output logic              rd_north_open,
  output logic              rd_east_open
);

  localparam int CELLS    = MAZE_W * MAZE_H;
  localparam int IDX_BITS = $clog2(CELLS);

  state_t              state;
  state_t              state_next;
  logic [X_BITS-1:0]   cur_x;
  logic [Y_BITS-1:0]   cur_y;
  logic [CELLS-1:0]    north_open;
  logic [CELLS-1:0]    east_open;
  logic [15:0]         lfsr_q;
  logic                lfsr_load;
  logic [15:0]         lfsr_load_val;
  logic                lfsr_unused;
  logic                accept;
  logic                last_x;
  logic                top_row;
  logic                last_cell;
  logic                carve_north;
  logic                carve_east;
  logic [IDX_BITS-1:0] wr_idx;
  logic [IDX_BITS-1:0] rd_idx;
  logic                rd_valid;

  assign accept = (state == IDLE) && start;

`ifdef MAZE_SEED_IN_EN
  assign lfsr_load     = accept;
  assign lfsr_load_val = seed_in;
`else
  assign lfsr_load     = 1'b0;
  assign lfsr_load_val = 16'h0000;
`endif

  maze_lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (lfsr_load),
    .load_val(lfsr_load_val),
    .q       (lfsr_q)
  );

  // Only the LSB steers carving; the rest of the state just feeds the sequence.
  assign lfsr_unused = ^lfsr_q[15:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CARVE;
      CARVE:   if (last_cell) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == CARVE);
  assign done = (state == DONE);

  assign last_x    = (cur_x == X_BITS'(MAZE_W - 1));
  assign top_row   = (cur_y == '0);
  assign last_cell = last_x && (cur_y == Y_BITS'(MAZE_H - 1));
  assign wr_idx    = IDX_BITS'(cur_y) * IDX_BITS'(MAZE_W) + IDX_BITS'(cur_x);

  // Row-major cursor; it wraps to (0,0) on the last cell, ready for the next run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_x <= '0;
      cur_y <= '0;
    end else if (state == CARVE) begin
      if (last_x) begin
        cur_x <= '0;
        cur_y <= last_cell ? '0 : cur_y + Y_BITS'(1);
      end else begin
        cur_x <= cur_x + X_BITS'(1);
      end
    end
  end

  // Binary-tree rule: the top row always links east and the right column always
  // links north, which keeps every cell connected to the top-right corner.
  always_comb begin
    carve_north = 1'b0;
    carve_east  = 1'b0;
    if (top_row && !last_x) begin
      carve_east = 1'b1;
    end else if (last_x && !top_row) begin
      carve_north = 1'b1;
    end else if (!last_x) begin
      carve_north = lfsr_q[0];
      carve_east  = ~lfsr_q[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      north_open <= '0;
      east_open  <= '0;
    end else if (state == CARVE) begin
      north_open[wr_idx] <= carve_north;
      east_open[wr_idx]  <= carve_east;
    end
  end

  assign rd_valid = (32'(rd_x) < MAZE_W) && (32'(rd_y) < MAZE_H);
  assign rd_idx   = IDX_BITS'(rd_y) * IDX_BITS'(MAZE_W) + IDX_BITS'(rd_x);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_north_open <= 1'b0;
      rd_east_open  <= 1'b0;
    end else if (rd_valid) begin
      rd_north_open <= north_open[rd_idx];
      rd_east_open  <= east_open[rd_idx];
    end else begin
      rd_north_open <= 1'b0;
      rd_east_open  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maze_generator.sv
// Self-checking bench for maze_generator: randomized start timing against a
// whole-maze reference built from the LFSR sequence and the carve rules.
module tb_maze_generator;

  localparam int W     = 8;
  localparam int H     = 6;
  localparam int CELLS = W * H;

  logic       clk = 1'b0;
  logic       reset;
  logic       start = 1'b0;
  logic [2:0] rd_x = 3'd0;
  logic [2:0] rd_y = 3'd0;
  logic       busy;
  logic       done;
  logic       rd_north_open;
  logic       rd_east_open;
`ifdef MAZE_SEED_IN_EN
  logic [15:0] seed_in = 16'h0000;
`endif

  int tests  = 0;
  int errors = 0;

  logic [15:0]      m_lfsr;
  int               m_left;
  logic [CELLS-1:0] m_north;
  logic [CELLS-1:0] m_east;
  logic [63:0]      obs_n;
  logic [63:0]      obs_e;

  maze_generator dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
`ifdef MAZE_SEED_IN_EN
    .seed_in      (seed_in),
`endif
    .rd_north_open(rd_north_open),
    .rd_east_open (rd_east_open)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] guard(input logic [15:0] v);
    return (v == 16'h0000) ? 16'h0001 : v;
  endfunction

  // Whole maze from the LFSR value seen by the first carved cell.
  function automatic logic [2*CELLS-1:0] build_maze(input logic [15:0] first);
    logic [CELLS-1:0] n;
    logic [CELLS-1:0] e;
    logic [15:0]      v;
    n = '0;
    e = '0;
    v = first;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y == 0 && x < W - 1) e[y*W+x] = 1'b1;
        else if (x == W - 1 && y > 0) n[y*W+x] = 1'b1;
        else if (x < W - 1) begin
          n[y*W+x] = v[0];
          e[y*W+x] = ~v[0];
        end
        v = step(v);
      end
    end
    return {e, n};
  endfunction

  // Reference: remaining-cycle count for the run plus the expected final maze.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lfsr  <= 16'hACE1;
      m_left  <= 0;
      m_north <= '0;
      m_east  <= '0;
    end else if (m_left == 0 && start) begin
      m_left <= CELLS + 1;
`ifdef MAZE_SEED_IN_EN
      m_lfsr            <= guard(seed_in);
      {m_east, m_north} <= build_maze(guard(seed_in));
`else
      m_lfsr            <= step(m_lfsr);
      {m_east, m_north} <= build_maze(step(m_lfsr));
`endif
    end else begin
      m_lfsr <= step(m_lfsr);
      if (m_left > 0) m_left <= m_left - 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Pulse start and follow the run; optionally fire stray starts mid-carve.
  task automatic applyStimulus(input bit noisy);
    int bad;
    bad = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_rise", 32'(busy), 32'd1);
    for (int i = 1; i <= CELLS; i++) begin
      if (noisy && (i == 5 || i == 20 || i == 40)) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (i < CELLS && (busy !== 1'b1 || done !== 1'b0)) bad++;
    end
    checkOutput("busy_during_carve", 32'(bad), 32'd0);
    checkOutput("done_at_48", 32'(done), 32'd1);
    checkOutput("busy_low_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("idle_after_done", 32'(busy), 32'd0);
    if (noisy) begin
      bad = 0;
      repeat (4) begin
        @(negedge clk);
        if (busy !== 1'b0 || done !== 1'b0) bad++;
      end
      checkOutput("no_restart", 32'(bad), 32'd0);
    end
  endtask

  // Pipelined scan of the full 8x8 address window through the read port.
  task automatic readMaze();
    for (int k = 0; k <= 64; k++) begin
      @(negedge clk);
      if (k > 0) begin
        obs_n[k-1] = rd_north_open;
        obs_e[k-1] = rd_east_open;
      end
      if (k < 64) begin
        rd_x = 3'(k % 8);
        rd_y = 3'(k / 8);
      end
    end
  endtask

  task automatic checkMaze(input bit full);
    int opens;
    int reached;
    int boundary_bad;
    bit seen[CELLS];
    readMaze();
    opens        = 0;
    boundary_bad = 0;
    for (int k = 0; k < 64; k++) begin
      int x;
      int y;
      x = k % 8;
      y = k / 8;
      if (y >= H) begin
        checkOutput("oob_read", 32'({obs_n[k], obs_e[k]}), 32'd0);
      end else begin
        checkOutput($sformatf("cell_%0d_%0d", x, y), 32'({obs_n[k], obs_e[k]}),
                    32'({m_north[y*W+x], m_east[y*W+x]}));
        opens += int'(obs_n[k]) + int'(obs_e[k]);
        if (y == 0 && x < W - 1) begin
          if (!(obs_e[k] && !obs_n[k])) boundary_bad++;
        end else if (x == W - 1 && y > 0) begin
          if (!(obs_n[k] && !obs_e[k])) boundary_bad++;
        end else if (x == W - 1) begin
          if (obs_n[k] || obs_e[k]) boundary_bad++;
        end else if (obs_n[k] == obs_e[k]) begin
          boundary_bad++;
        end
      end
    end
    if (full) begin
      checkOutput("open_bits", 32'(opens), 32'(CELLS - 1));
      checkOutput("boundary_rules", 32'(boundary_bad), 32'd0);
      foreach (seen[i]) seen[i] = 1'b0;
      seen[0] = 1'b1;
      repeat (CELLS) begin
        for (int j = 0; j < CELLS; j++) begin
          if (obs_n[j] && j >= W && (seen[j] || seen[j-W])) begin
            seen[j]   = 1'b1;
            seen[j-W] = 1'b1;
          end
          if (obs_e[j] && (j % W) < W - 1 && (seen[j] || seen[j+1])) begin
            seen[j]   = 1'b1;
            seen[j+1] = 1'b1;
          end
        end
      end
      reached = 0;
      foreach (seen[i]) reached += int'(seen[i]);
      checkOutput("bfs_reached", 32'(reached), 32'(CELLS));
    end else begin
      checkOutput("open_bits_cleared", 32'(opens), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_rd", 32'({rd_north_open, rd_east_open}), 32'd0);
    reset = 1'b1;
    checkMaze(1'b0);

    applyStimulus(1'b0);
    checkMaze(1'b1);

    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(0, 30)) @(negedge clk);
      applyStimulus(r == 3 || r == 11);
      checkMaze(1'b1);
    end

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midrun_reset_rd", 32'({rd_north_open, rd_east_open}), 32'd0);
    checkOutput("midrun_reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    checkOutput("midrun_reset_idle", 32'({busy, done}), 32'd0);
    checkMaze(1'b0);
    repeat ($urandom_range(1, 20)) @(negedge clk);
    applyStimulus(1'b0);
    checkMaze(1'b1);

`ifdef MAZE_SEED_IN_EN
    begin
      logic [63:0] first_n;
      logic [63:0] first_e;
      seed_in = 16'h1234;
      applyStimulus(1'b0);
      checkMaze(1'b1);
      first_n = obs_n;
      first_e = obs_e;
      repeat ($urandom_range(1, 30)) @(negedge clk);
      applyStimulus(1'b0);
      checkMaze(1'b1);
      checkOutput("seed_repeat_diff", 32'($countones({obs_n ^ first_n, obs_e ^ first_e})), 32'd0);
      seed_in = 16'h0000;
      applyStimulus(1'b0);
      checkMaze(1'b1);
      first_n = obs_n;
      first_e = obs_e;
      seed_in = 16'h0001;
      applyStimulus(1'b0);
      checkMaze(1'b1);
      checkOutput("seed_zero_diff", 32'($countones({obs_n ^ first_n, obs_e ^ first_e})), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
